// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the bimodal branch predictor: counter encodings
// and default geometry.
package branch_predictor_pkg;

   // Default log2 of the branch history table depth (64 entries).
   localparam int BP_INDEX_BITS = 6;

   // Default width of the resolved-branch statistics counters.
   localparam int BP_STAT_WIDTH = 16;

   // 2-bit saturating counter states; bit 1 is the taken/not-taken prediction.
   typedef enum logic [1:0] {
      BP_STRONG_NT = 2'b00,
      BP_WEAK_NT   = 2'b01,
      BP_WEAK_T    = 2'b10,
      BP_STRONG_T  = 2'b11
   } bp_counter_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating counter: moves one step toward
// taken or not-taken and holds at either end instead of wrapping.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] value,
   input  logic       taken,
   output logic [1:0] next_value
);

   // Step toward the resolved direction, saturating at the strong states.
   always_comb begin
      next_value = value;
      if (taken) begin
         if (value != BP_STRONG_T) begin
            next_value = value + 2'd1;
         end
      end else begin
         if (value != BP_STRONG_NT) begin
            next_value = value - 2'd1;
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// the word-aligned low PC bits, looked up combinationally in ID and trained
// by branches resolving in EX, plus misprediction pulse and statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int STAT_WIDTH = BP_STAT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_id_branch,
   input  logic [31:0]           i_id_pc,
   output logic                  o_prediction,
   input  logic                  i_ex_update,
   input  logic [31:0]           i_ex_pc,
   input  logic                  i_ex_taken,
   input  logic                  i_ex_predicted,
   output logic                  o_mispredict,
   output logic [STAT_WIDTH-1:0] o_branch_count,
   output logic [STAT_WIDTH-1:0] o_mispredict_count
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [INDEX_BITS-1:0] id_index;
   logic [INDEX_BITS-1:0] ex_index;
   logic [1:0]            bht [ENTRIES];
   logic [1:0]            id_value;
   logic [1:0]            ex_value;
   logic [1:0]            update_next;
   logic [1:0]            bypass_next;
   logic                  bypass_hit;
   logic                  mispredict;

   logic                  mispredict_reg;
   logic [STAT_WIDTH-1:0] branch_count_reg;
   logic [STAT_WIDTH-1:0] mispredict_count_reg;

   // Upper PC bits and the byte offset do not take part in indexing;
   // aliasing between branches sharing low bits is accepted.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_id_pc[31:INDEX_BITS+2], i_id_pc[1:0],
                             i_ex_pc[31:INDEX_BITS+2], i_ex_pc[1:0]};

   assign id_index = i_id_pc[INDEX_BITS+1:2];
   assign ex_index = i_ex_pc[INDEX_BITS+1:2];
   assign id_value = bht[id_index];
   assign ex_value = bht[ex_index];

   // Trained value for the entry being written this cycle.
   sat_counter2 u_update (
      .value      (ex_value),
      .taken      (i_ex_taken),
      .next_value (update_next)
   );

   // Post-update value of the looked-up entry, used when ID and EX collide.
   sat_counter2 u_bypass (
      .value      (id_value),
      .taken      (i_ex_taken),
      .next_value (bypass_next)
   );

   // Register-array table: every entry resets to weak-not-taken in one cycle.
   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : gen_bht
         logic [1:0] entry_reg;

         // Per-entry counter: reset wins over a simultaneous update.
         always_ff @(posedge clk) begin
            if (reset) begin
               entry_reg <= BP_WEAK_NT;
            end else if (i_ex_update && (ex_index == INDEX_BITS'(gi))) begin
               entry_reg <= update_next;
            end
         end

         assign bht[gi] = entry_reg;
      end
   endgenerate

   // Write-first lookup: a same-index update in flight is forwarded, except
   // while reset is held since that update will be discarded.
   always_comb begin
      bypass_hit   = i_ex_update && !reset && (id_index == ex_index);
      o_prediction = 1'b0;
      if (i_id_branch) begin
         if (bypass_hit) begin
            o_prediction = bypass_next[1];
         end else begin
            o_prediction = id_value[1];
         end
      end
   end

   assign mispredict = i_ex_taken ^ i_ex_predicted;

   // Misprediction pulse and saturating statistics, updated per resolved branch.
   always_ff @(posedge clk) begin
      if (reset) begin
         mispredict_reg       <= 1'b0;
         branch_count_reg     <= '0;
         mispredict_count_reg <= '0;
      end else if (i_ex_update) begin
         mispredict_reg <= mispredict;
         if (branch_count_reg != {STAT_WIDTH{1'b1}}) begin
            branch_count_reg <= branch_count_reg + 1'b1;
         end
         if (mispredict && (mispredict_count_reg != {STAT_WIDTH{1'b1}})) begin
            mispredict_count_reg <= mispredict_count_reg + 1'b1;
         end
      end else begin
         mispredict_reg <= 1'b0;
      end
   end

   assign o_mispredict       = mispredict_reg;
   assign o_branch_count     = branch_count_reg;
   assign o_mispredict_count = mispredict_count_reg;

endmodule
